// File: rtl/gmii_tx_sched.sv
// gmii_tx_sched: frame scheduler in front of the GMII transmitter.
// It counts the video lines waiting in the pixel FIFO and grants one frame at a time,
// either a video frame or an audio frame. Audio is forced after a bounded number of
// consecutive video grants. A grant that never sees tx_done is aborted by a watchdog.
// Optional build macro: SCHED_STATS_EN adds the frame and abort statistics counters.
module gmii_tx_sched #(
    parameter int PKTS_PER_LINE = 2,
    parameter int LINE_Q_DEPTH  = 4,
    parameter int AUD_MIN_ADE   = 1,
    parameter int AUD_MAX_DEFER = 2,
    parameter int TX_TIMEOUT    = 4095
) (
    input  logic        tx_clk,
    input  logic        sys_rst_n,
    input  logic        line_rdy,
    input  logic        vid_empty,
    input  logic        aud_empty,
    input  logic [3:0]  aud_cnt,
    input  logic        tx_done,
    output logic        send_vid,
    output logic        send_aud,
    output logic [2:0]  line_pend,
    output logic        q_ovf,
    output logic        tx_abort
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0] vid_pkts,
    output logic [15:0] aud_pkts,
    output logic [7:0]  abort_cnt
`endif
);

    localparam logic [3:0]  AUD_MIN   = 4'(AUD_MIN_ADE);
    localparam logic [2:0]  LINE_MAX  = 3'(LINE_Q_DEPTH);
    localparam logic [1:0]  DEFER_MAX = 2'(AUD_MAX_DEFER);
    localparam logic [1:0]  PKT_LAST  = 2'(PKTS_PER_LINE - 1);
    localparam logic [11:0] WDOG_MAX  = 12'(TX_TIMEOUT);

    typedef enum logic [1:0] {IDLE, VID, AUD} state_t;

    state_t      state;
    logic [11:0] wdog;         // current grant cycle number, 1-based
    logic [1:0]  defer;        // video grants taken while audio was waiting
    logic [1:0]  pkt_in_line;

    logic vid_ok, aud_ok, done_vid, retire;

    // Eligibility and line retirement
    always_comb begin
        vid_ok   = (line_pend != 3'd0) && !vid_empty;
        aud_ok   = !aud_empty && (aud_cnt >= AUD_MIN);
        done_vid = (state == VID) && tx_done;
        retire   = done_vid && (pkt_in_line == PKT_LAST);
    end

    // Grant FSM with registered grants, watchdog and audio deferral counter
    always_ff @(posedge tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            send_vid <= 1'b0;
            send_aud <= 1'b0;
            tx_abort <= 1'b0;
            wdog     <= 12'd0;
            defer    <= 2'd0;
        end else begin
            tx_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (aud_ok && (defer >= DEFER_MAX || !vid_ok)) begin
                        state    <= AUD;
                        send_aud <= 1'b1;
                        defer    <= 2'd0;
                        wdog     <= 12'd1;
                    end else if (vid_ok) begin
                        state    <= VID;
                        send_vid <= 1'b1;
                        wdog     <= 12'd1;
                        if (aud_ok && defer != 2'd3)
                            defer <= defer + 2'd1;
                    end
                end
                VID, AUD: begin
                    // tx_done takes precedence over the timeout if both fall on the same cycle
                    if (tx_done) begin
                        state    <= IDLE;
                        send_vid <= 1'b0;
                        send_aud <= 1'b0;
                    end else if (wdog == WDOG_MAX) begin
                        state    <= IDLE;
                        send_vid <= 1'b0;
                        send_aud <= 1'b0;
                        tx_abort <= 1'b1;
                    end else begin
                        wdog <= wdog + 12'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    send_vid <= 1'b0;
                    send_aud <= 1'b0;
                end
            endcase
        end
    end

    // Line queue accounting: an aborted frame earns no packet credit
    always_ff @(posedge tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pkt_in_line <= 2'd0;
            line_pend   <= 3'd0;
            q_ovf       <= 1'b0;
        end else begin
            if (done_vid)
                pkt_in_line <= retire ? 2'd0 : pkt_in_line + 2'd1;
            if (line_rdy && line_pend == LINE_MAX)
                q_ovf <= 1'b1;
            if (line_rdy && !retire && line_pend != LINE_MAX)
                line_pend <= line_pend + 3'd1;
            else if (retire && !line_rdy)
                line_pend <= line_pend - 3'd1;
        end
    end

`ifdef SCHED_STATS_EN
    // Wrapping counts of completed frames and aborts
    always_ff @(posedge tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vid_pkts  <= 16'd0;
            aud_pkts  <= 16'd0;
            abort_cnt <= 8'd0;
        end else begin
            if (done_vid)
                vid_pkts <= vid_pkts + 16'd1;
            if (state == AUD && tx_done)
                aud_pkts <= aud_pkts + 16'd1;
            if (state != IDLE && !tx_done && wdog == WDOG_MAX)
                abort_cnt <= abort_cnt + 8'd1;
        end
    end
`endif

endmodule
